// File: rtl/tmr2_pkg.sv
// tmr2_pkg: shared types and defaults for the tmr2 differential-code link.
package tmr2_pkg;

   localparam int TMR2_WIDTH = 8;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } tmr2_dec_state_t;

endpackage

// File: rtl/tmr2_dec_fifo.sv
// tmr2_dec_fifo: 2-entry first-word-fall-through FIFO; slot s0 is always the head.
module tmr2_dec_fifo #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   cnt
);

   logic [W-1:0] s0, s1;
   logic         wr, rd;

   assign wr   = push && (cnt != 2'd2);
   assign rd   = pop && (cnt != 2'd0);
   assign dout = s0;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s0  <= '0;
         s1  <= '0;
         cnt <= '0;
      end else begin
         if (rd) begin
            if (cnt == 2'd2) s0 <= s1;
            else if (wr) s0 <= din;
         end else if (wr) begin
            if (cnt == 2'd0) s0 <= din;
            else s1 <= din;
         end
         cnt <= cnt + 2'(wr) - 2'(rd);
      end

endmodule

// File: rtl/tmr2_dec.sv
// tmr2_dec: recovers data words from the tmr2 running-XOR code, tracks lock and counts dropped words.
module tmr2_dec
   import tmr2_pkg::*;
#(
   parameter int WIDTH         = TMR2_WIDTH,
   parameter int ERR_W         = 8,
   parameter bit LOCK_AT_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sync,
   input  logic [WIDTH-1:0] in_data,
   input  logic             unlock,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sync,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   tmr2_dec_state_t  state;
   logic [WIDTH-1:0] prev, dec;
   logic [1:0]       cnt;
   logic             xfer, push, drop;

   assign in_ready  = ~cnt[1];
   assign out_valid = cnt != 2'd0;
   assign locked    = state == LOCKED;
   assign xfer      = in_valid && in_ready;
   // unlock wins over the word in flight: it is consumed but never decoded
   assign push      = xfer && !unlock && (in_sync || state == LOCKED);
   assign drop      = xfer && !in_sync && (unlock || state == UNLOCKED);
   assign dec       = (state == LOCKED && !in_sync) ? in_data ^ prev : in_data;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= LOCK_AT_RESET ? LOCKED : UNLOCKED;
         prev    <= '0;
         err_cnt <= '0;
      end else begin
         state <= unlock ? UNLOCKED : (xfer && in_sync) ? LOCKED : state;
         if (push) prev <= in_data;
         if (drop && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end

   tmr2_dec_fifo #(.W(WIDTH + 1)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (out_ready),
      .din  ({in_sync, dec}),
      .dout ({out_sync, out_data}),
      .cnt  (cnt)
   );

endmodule

// File: tb/tb_tmr2_dec.sv
// tb_tmr2_dec: random and directed checks of two tmr2_dec instances (locked / unlocked at reset) against a queue model.
module tb_tmr2_dec;

   logic       clk = 0, rst = 1;
   logic       in_valid = 0, in_sync = 0, unlock = 0, out_ready = 0;
   logic [7:0] in_data = 0;
   logic [1:0] ir, ov, os, lkd;
   logic [7:0] od [2];
   logic [7:0] ec [2];

   int         total = 0, bad = 0;
   bit         lk [2];
   logic [7:0] pv [2];
   int         er [2];
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [7:0] expq [$];
   bit         lb = 0;

   always #5 clk = ~clk;

   tmr2_dec #(.LOCK_AT_RESET(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_sync(in_sync),
      .in_data(in_data), .unlock(unlock), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_sync(os[0]), .locked(lkd[0]), .err_cnt(ec[0])
   );

   tmr2_dec #(.LOCK_AT_RESET(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_sync(in_sync),
      .in_data(in_data), .unlock(unlock), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_sync(os[1]), .locked(lkd[1]), .err_cnt(ec[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int e);
      return e < 255 ? e + 1 : 255;
   endfunction

   task automatic mreset();
      lk[0] = 1; lk[1] = 0;
      pv[0] = 0; pv[1] = 0;
      er[0] = 0; er[1] = 0;
      q0.delete(); q1.delete();
   endtask

   // one rising edge of the reference: pop the head, then apply the decode rules
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int         sz;
         bit         x, pop, push;
         logic [8:0] w;
         sz   = (k == 0) ? q0.size() : q1.size();
         x    = in_valid && sz < 2;
         pop  = sz > 0 && out_ready;
         push = 0;
         w    = 0;
         if (pop) begin
            if (k == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
         end
         if (unlock) begin
            lk[k] = 0;
            if (x && !in_sync) er[k] = sat(er[k]);
         end else if (x) begin
            if (in_sync) begin
               w = {1'b1, in_data}; push = 1; pv[k] = in_data; lk[k] = 1;
            end else if (lk[k]) begin
               w = {1'b0, in_data ^ pv[k]}; push = 1; pv[k] = in_data;
            end else er[k] = sat(er[k]);
         end
         if (push) begin
            if (k == 0) q0.push_back(w);
            else q1.push_back(w);
         end
      end
   endtask

   task automatic cmp_all();
      for (int k = 0; k < 2; k++) begin
         int         sz;
         logic [8:0] h;
         sz = (k == 0) ? q0.size() : q1.size();
         chk("valid", ov[k], sz > 0);
         chk("ready", ir[k], sz < 2);
         chk("locked", lkd[k], lk[k]);
         chk("err", ec[k], er[k]);
         if (sz > 0) begin
            h = (k == 0) ? q0[0] : q1[0];
            chk("data", od[k], h[7:0]);
            chk("sync", os[k], h[8]);
         end
      end
   endtask

   task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic u, input logic r);
      @(negedge clk);
      in_valid = v; in_sync = s; in_data = d; unlock = u; out_ready = r;
      if (lb && ov[0] && r) begin
         if (expq.size() == 0) chk("lb_extra", 1, 0);
         else chk("lb_data", od[0], expq.pop_front());
      end
      @(posedge clk);
      model_edge();
      #1 cmp_all();
   endtask

   // reset is dropped mid-cycle so its asynchronous effect is observed before any edge
   task automatic do_reset();
      #2 rst = 0;
      mreset();
      #1 cmp_all();
      chk("rst_data0", od[0], 0);
      chk("rst_data1", od[1], 0);
      @(negedge clk);
      in_valid = 0; unlock = 0;
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      bit         sel, acc;
      logic [7:0] d, e, ep;
      mreset();
      #2 rst = 0;
      #1 cmp_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1;

      cyc(1, 0, 8'h5A, 0, 1);
      chk("t1_first", od[0], 8'h5A);
      cyc(1, 0, 8'h0F, 0, 1);
      chk("t1_second", od[0], 8'h55);
      chk("t1_err", ec[0], 0);

      do_reset();
      cyc(1, 0, 8'h11, 0, 1);
      chk("t2_err", ec[1], 1);
      chk("t2_unlocked", lkd[1], 0);
      cyc(1, 1, 8'h3C, 0, 1);
      chk("t2_sync_data", od[1], 8'h3C);
      chk("t2_sync_flag", os[1], 1);
      chk("t2_locked", lkd[1], 1);
      cyc(1, 0, 8'hFF, 0, 1);
      chk("t2_diff", od[1], 8'hC3);

      do_reset();
      cyc(1, 1, 8'hA1, 0, 0);
      chk("t4_ready1", ir[0], 1);
      cyc(1, 0, 8'hB2, 0, 0);
      chk("t4_full", ir[0], 0);
      cyc(1, 0, 8'hC3, 0, 0);
      chk("t4_hold", od[0], 8'hA1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("t4_drain", od[0], 8'h13);
      chk("t4_ready2", ir[0], 1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("t4_empty", ov[0], 0);

      do_reset();
      cyc(1, 1, 8'h10, 0, 1);
      cyc(1, 0, 8'h01, 1, 1);
      chk("t5_unlocked", lkd[0], 0);
      chk("t5_err", ec[0], 1);
      chk("t5_dropped", ov[0], 0);
      cyc(1, 1, 8'h80, 0, 1);
      chk("t5_relock", od[0], 8'h80);
      chk("t5_locked", lkd[0], 1);

      do_reset();
      cyc(1, 0, 8'h00, 1, 1);
      for (int i = 0; i < 300; i++) cyc(1, 0, 8'($urandom), 0, 1);
      chk("t6_sat0", ec[0], 8'hFF);
      chk("t6_sat1", ec[1], 8'hFF);
      cyc(1, 1, 8'h77, 0, 0);
      cyc(1, 1, 8'h66, 0, 0);
      chk("t6_full", ov, 2'b11);
      in_valid = 1;
      do_reset();

      for (int i = 0; i < 300; i++)
         cyc($urandom % 4 != 0, $urandom % 3 == 0, 8'($urandom), $urandom % 20 == 0, $urandom % 4 != 0);

      do_reset();
      lb = 1;
      ep = 0;
      for (int i = 0; i < 64; i++) begin
         sel = ($urandom % 4) == 0;
         d   = 8'($urandom);
         e   = sel ? d : d ^ ep;
         expq.push_back(d);
         acc = 0;
         for (int t = 0; t < 50 && !acc; t++) begin
            acc = q0.size() < 2;
            cyc(1, sel, e, 0, 1'($urandom % 2));
         end
         if (!acc) chk("lb_stall", 0, 1);
         ep = e;
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 0, 1);
      chk("lb_left", expq.size(), 0);
      lb = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
